// File: rtl/ghash_aggregated_accumulator.sv
// GHASH accumulator that folds up to N_BLOCKS blocks per beat using aggregated
// reduction: Y' = (Y ^ X1)*H^k ^ X2*H^(k-1) ^ ... ^ Xk*H^1 over GF(2^128), GCM bit order.
module ghash_aggregated_accumulator #(
  parameter int NB_BLOCK = 128,
  parameter int N_BLOCKS = 2,
  parameter int NB_DATA  = NB_BLOCK * N_BLOCKS,
  parameter int NB_NBLK  = $clog2(N_BLOCKS + 1)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic [NB_NBLK-1:0]  i_n_blocks,
  input  logic                i_valid,
  input  logic                i_sop,
  input  logic                i_eop,
  input  logic [NB_DATA-1:0]  i_h_key_powers,
  output logic [NB_BLOCK-1:0] o_ghash,
  output logic                o_ghash_valid,
  output logic                o_busy
);

  generate
    if (NB_BLOCK != 128 || N_BLOCKS < 1 || N_BLOCKS > 8) begin : g_bad_conf
      $error("ghash_aggregated_accumulator: BAD_CONF (NB_BLOCK must be 128, N_BLOCKS 1..8)");
    end
  endgenerate

  localparam logic [NB_BLOCK-1:0] R_POLY = {8'he1, {(NB_BLOCK-8){1'b0}}};

  // Bit-serial GF(2^128) product in GCM bit order (MSB is the x^0 coefficient).
  function automatic logic [NB_BLOCK-1:0] gf_mul(input logic [NB_BLOCK-1:0] x,
                                                  input logic [NB_BLOCK-1:0] y);
    logic [NB_BLOCK-1:0] z;
    logic [NB_BLOCK-1:0] v;
    logic [NB_BLOCK-1:0] xs;
    z  = '0;
    v  = y;
    xs = x;
    for (int unsigned i = 0; i < NB_BLOCK; i++) begin
      if (xs[NB_BLOCK-1]) z = z ^ v;
      v  = v[0] ? ((v >> 1) ^ R_POLY) : (v >> 1);
      xs = xs << 1;
    end
    return z;
  endfunction

  logic [NB_NBLK-1:0]  k_eff;
  logic                accept;
  logic [NB_BLOCK-1:0] acc;
  logic [NB_BLOCK-1:0] y_base;
  logic                busy_q;
  logic                valid_q;

  logic [NB_BLOCK-1:0] pow_lane  [N_BLOCKS];
  logic [NB_BLOCK-1:0] lane_prod [N_BLOCKS];
  logic [NB_BLOCK-1:0] xor_chain [N_BLOCKS+1];

  assign k_eff  = (i_n_blocks > NB_NBLK'(N_BLOCKS)) ? NB_NBLK'(N_BLOCKS) : i_n_blocks;
  assign accept = i_valid && (k_eff != '0);
  assign y_base = i_sop ? '0 : acc;

  assign xor_chain[0] = '0;

  generate
    for (genvar j = 0; j < N_BLOCKS; j++) begin : g_lane
      logic [NB_BLOCK-1:0] pow_chain [N_BLOCKS+1];
      logic [NB_BLOCK-1:0] operand;
      logic                active;

      assign pow_lane[j] = i_h_key_powers[j*NB_BLOCK +: NB_BLOCK];
      assign active      = (k_eff > NB_NBLK'(j));

      // Lane j takes H^(k-j): an AND-OR mux over power lanes m where k == j+m+1.
      assign pow_chain[0] = '0;
      for (genvar m = 0; m < N_BLOCKS; m++) begin : g_pow
        if (j + m + 1 <= N_BLOCKS) begin : g_hit
          assign pow_chain[m+1] = pow_chain[m] |
                                  ((k_eff == NB_NBLK'(j + m + 1)) ? pow_lane[m] : '0);
        end else begin : g_miss
          assign pow_chain[m+1] = pow_chain[m];
        end
      end

      if (j == 0) begin : g_first
        assign operand = i_data[j*NB_BLOCK +: NB_BLOCK] ^ y_base;
      end else begin : g_rest
        assign operand = i_data[j*NB_BLOCK +: NB_BLOCK];
      end

      assign lane_prod[j]   = active ? gf_mul(operand, pow_chain[N_BLOCKS]) : '0;
      assign xor_chain[j+1] = xor_chain[j] ^ lane_prod[j];
    end
  endgenerate

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      acc     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= accept && i_eop;
      if (accept) begin
        acc <= xor_chain[N_BLOCKS];
        if (i_eop)      busy_q <= 1'b0;
        else if (i_sop) busy_q <= 1'b1;
      end
    end
  end

  assign o_ghash       = acc;
  assign o_ghash_valid = valid_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_ghash_aggregated_accumulator.sv
// Self-checking bench for ghash_aggregated_accumulator: block-serial GHASH reference
// model (polynomial-basis multiply) compared every cycle, plus literal pins.
module tb_ghash_aggregated_accumulator;

  localparam int NB_BLOCK = 128;
  localparam int N_BLOCKS = 2;
  localparam int NB_DATA  = NB_BLOCK * N_BLOCKS;
  localparam int NB_NBLK  = $clog2(N_BLOCKS + 1);

  localparam logic [127:0] E_ID = {1'b1, 127'b0};

  logic                clk = 1'b0;
  logic                rst;
  logic [NB_DATA-1:0]  data;
  logic [NB_NBLK-1:0]  n_blocks;
  logic                valid;
  logic                sop;
  logic                eop;
  logic [NB_DATA-1:0]  powers;
  logic [NB_BLOCK-1:0] ghash;
  logic                ghash_valid;
  logic                busy;

  ghash_aggregated_accumulator #(
    .NB_BLOCK(NB_BLOCK),
    .N_BLOCKS(N_BLOCKS)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_data         (data),
    .i_n_blocks     (n_blocks),
    .i_valid        (valid),
    .i_sop          (sop),
    .i_eop          (eop),
    .i_h_key_powers (powers),
    .o_ghash        (ghash),
    .o_ghash_valid  (ghash_valid),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [127:0] h_model;
  logic [127:0] exp_acc;
  logic         exp_valid;
  logic         exp_busy;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [127:0] rev(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[7'(i)] = a[7'(127 - i)];
    return r;
  endfunction

  // Conventional polynomial basis: reverse bits, carry-less multiply, reduce, reverse back.
  function automatic logic [127:0] gf_ref(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] ar;
    logic [127:0] br;
    logic [254:0] p;
    ar = rev(a);
    br = rev(b);
    p  = '0;
    for (int i = 0; i < 128; i++)
      if (ar[7'(i)]) p = p ^ ({127'b0, br} << i);
    for (int i = 254; i >= 128; i--)
      if (p[8'(i)]) p = p ^ ({126'b0, 1'b1, 120'b0, 8'h87} << (i - 128));
    return rev(p[127:0]);
  endfunction

  function automatic logic [127:0] fold(input logic [127:0] y, input logic [NB_DATA-1:0] d,
                                        input int k, input logic [127:0] h);
    logic [127:0] r;
    r = y;
    for (int b = 0; b < k; b++) r = gf_ref(r ^ d[b*128 +: 128], h);
    return r;
  endfunction

  function automatic int clamp_k(input logic [NB_NBLK-1:0] k);
    return (int'(k) > N_BLOCKS) ? N_BLOCKS : int'(k);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_acc   <= '0;
      exp_valid <= 1'b0;
      exp_busy  <= 1'b0;
    end else begin
      exp_valid <= valid && (clamp_k(n_blocks) > 0) && eop;
      if (valid && clamp_k(n_blocks) > 0) begin
        exp_acc <= fold(sop ? 128'b0 : exp_acc, data, clamp_k(n_blocks), h_model);
        if (eop)      exp_busy <= 1'b0;
        else if (sop) exp_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ghash", ghash, exp_acc);
      check("ghash_valid", {127'b0, ghash_valid}, {127'b0, exp_valid});
      check("busy", {127'b0, busy}, {127'b0, exp_busy});
    end
  end

  task automatic set_h(input logic [127:0] h);
    h_model = h;
    powers  = {gf_ref(h, h), h};
  endtask

  // Called right after a negedge; returns at the following negedge.
  task automatic beat(input logic r, input logic v, input logic s, input logic e,
                      input logic [NB_NBLK-1:0] k, input logic [127:0] x1, input logic [127:0] x2);
    rst      = r;
    valid    = v;
    sop      = s;
    eop      = e;
    n_blocks = k;
    data     = {x2, x1};
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 1'b0, NB_NBLK'(0), $urandom(), $urandom());
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [127:0] blk [7];

  initial begin
    rst = 1'b1; valid = 1'b0; sop = 1'b0; eop = 1'b0; n_blocks = '0; data = '0;
    set_h(E_ID);
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("idle_ghash", ghash, 128'h0);
      check("idle_valid", {127'b0, ghash_valid}, 128'h0);
      check("idle_busy", {127'b0, busy}, 128'h0);
    end

    set_h(E_ID);
    beat(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 128'h1, 128'h2);
    check("ident_b1", ghash, 128'h3);
    check("ident_b1_busy", {127'b0, busy}, 128'h1);
    beat(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 128'h4, rand128());
    check("ident_b2", ghash, 128'h7);
    check("ident_b2_valid", {127'b0, ghash_valid}, 128'h1);
    check("ident_b2_busy", {127'b0, busy}, 128'h0);
    idle(1);
    check("ident_pulse_end", {127'b0, ghash_valid}, 128'h0);

    set_h(128'h0);
    beat(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, rand128(), rand128());
    check("zero_pow", ghash, 128'h0);
    check("zero_pow_valid", {127'b0, ghash_valid}, 128'h1);
    idle(1);

    set_h(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    beat(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 128'h0388dace60b6a392f328c2b971b2fe78, 128'h80);
    check("nist_tc2", ghash, 128'hf38cbb1ad69223dcc3457ae5b6b0f885);
    check("nist_tc2_model", exp_acc, 128'hf38cbb1ad69223dcc3457ae5b6b0f885);
    idle(2);

    set_h(rand128());
    for (int i = 0; i < 7; i++) blk[i] = rand128();
    beat(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, blk[0], blk[1]);
    beat(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, rand128(), rand128());
    idle(2);
    beat(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, blk[2], blk[3]);
    beat(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, blk[4], blk[5]);
    beat(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, blk[6], rand128());
    check("seven_blk_valid", {127'b0, ghash_valid}, 128'h1);
    idle(1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) set_h(rand128());
      beat($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           NB_NBLK'($urandom_range(0, 3)), rand128(), rand128());
    end
    idle(1);

    set_h(rand128());
    beat(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, rand128(), rand128());
    beat(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, rand128(), rand128());
    check("rst_eop_ghash", ghash, 128'h0);
    check("rst_eop_valid", {127'b0, ghash_valid}, 128'h0);
    check("rst_eop_busy", {127'b0, busy}, 128'h0);
    set_h(E_ID);
    beat(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 128'h5, rand128());
    check("after_rst", ghash, 128'h5);
    check("after_rst_valid", {127'b0, ghash_valid}, 128'h1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ghash_aggregated_accumulator.md
# ghash_aggregated_accumulator

Consumer of the H-key power table in the GHASH core: folds up to N_BLOCKS 128-bit data blocks per cycle into the running GHASH accumulator with aggregated reduction. One beat computes Y' = (Y ^ X1)·H^k ^ X2·H^(k-1) ^ … ^ Xk·H^1 over GF(2^128) in GCM bit order. Each beat carries k valid blocks. The powers come from the H-key power table, and the block holds one accumulator register plus its output flags.

## Interface
- NB_BLOCK, 128, block width; any other value is a bad configuration (BAD_CONF).
- N_BLOCKS, 2, blocks per beat; legal range 1..8.
- NB_DATA, NB_BLOCK*N_BLOCKS, data and power-bus width.
- NB_NBLK, $clog2(N_BLOCKS+1), width of the valid-block count.
- i_clock  in  1  the only clock; all state changes on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_data  in  NB_DATA  lane j at bits [j*NB_BLOCK +: NB_BLOCK] is message block X(j+1); lane 0 is the oldest block.
- i_n_blocks  in  NB_NBLK  number of valid lanes k, counted from lane 0.
- i_valid  in  1  the beat is valid this cycle.
- i_sop  in  1  first beat of a message; use Y = 0 in place of the accumulator.
- i_eop  in  1  last beat of a message.
- i_h_key_powers  in  NB_DATA  lane m holds H^(m+1), in power-table format.
- o_ghash  out  NB_BLOCK  accumulator value.
- o_ghash_valid  out  1  one-cycle pulse: o_ghash is the final tag hash of a message.
- o_busy  out  1  high between an accepted i_sop and the accepted i_eop.

## Operation
- Multiplication uses the codebase multiplier_without_pipe followed by gf_2to128_multiplier_booth1_subrem, the same polynomial and bit order as the power table.
  - One multiplier per lane, N_BLOCKS in total, all combinational.
  - Identity element E = 128'h8000…0000.
- Lane j's operand is X(j+1), with X1 replaced by Y ^ X1.
- Lane j selects power H^(k-j), i.e. power lane k-j-1, through a per-lane mux over the power lanes.
- Lanes j ≥ k contribute 0 and their data bits are ignored.
- The products of all lanes are XORed into Y'. Width stays NB_BLOCK throughout; there is no carry.
- Y is the accumulator register, or 0 when i_sop=1.
- An update happens only when i_valid=1 and the effective k ≥ 1.
  - k = 0 with i_valid=1: beat ignored, no state change, no flags.
  - k > N_BLOCKS: clamped to N_BLOCKS.
- i_valid=0: accumulator, o_busy and o_ghash hold; o_ghash_valid=0.
- o_busy is set by an accepted i_sop beat without i_eop, and cleared by an accepted i_eop beat.
- A beat without i_sop while o_busy=0 continues from the held accumulator (used for AAD followed by ciphertext across calls). This is legal.
- Accepted i_sop and i_eop on the same beat: single-beat message, o_busy stays 0.
- i_sop while o_busy=1: the previous message is abandoned with no valid pulse; the new message starts from 0.
- i_h_key_powers must be stable during any cycle with i_valid=1. It is sampled combinationally and never stored.

## Timing
- Reset values: accumulator/o_ghash = 0, o_ghash_valid = 0, o_busy = 0.
- i_reset overrides a simultaneous valid beat, whether mid-message or on i_eop. There is no pulse for the aborted message.
- Latency is 1 cycle: a beat accepted at edge n is visible on o_ghash after edge n.
  - o_ghash_valid is high for exactly the cycle after the edge that accepted i_eop.
- Throughput: one beat per cycle, no back-pressure, no ready signal.
- Back-to-back messages (i_eop beat followed by an i_sop beat in the next cycle) are supported.
  - o_ghash shows message A's hash for one cycle with o_ghash_valid=1, then message B's first partial value.
- Critical path: power mux → multiplier → reduction → N-input XOR. No internal pipelining; the accumulator is the only state besides the flags.

## Test plan
- Reset then idle for 5 cycles → o_ghash=0, o_ghash_valid=0, o_busy=0 every cycle.
- N_BLOCKS=2, all power lanes = E. Beat 1: sop=1, eop=0, k=2, X1=128'h1, X2=128'h2. Beat 2: sop=0, eop=1, k=1, X1=128'h4.
  - o_busy=1 after beat 1, then 0.
  - o_ghash = 128'h3 after beat 1, then 128'h7 with o_ghash_valid=1.
- Powers = 0, any data, k=2, sop=1, eop=1 → o_ghash = 0 with a valid pulse.
- Random H: load the powers from h_key_power_table and send a 7-block message as beats with k = 2,2,2,1.
  - Must match a bit-serial GCM GHASH model, e.g. the NIST GCM test case 2 hash 128'hf38cbb1ad69223dcc3457ae5b6b0f885 for H = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e.
- Beats with k=0, and i_valid low between beats → no change and no pulse. k=3 with N_BLOCKS=2 → same result as k=2.
- Assert i_reset on the i_eop beat → o_ghash=0, no pulse.
  - A following beat with sop=1, eop=1, powers = E, k=1, X1=128'h5 gives o_ghash = 128'h5 with a valid pulse.
